// File: rtl/sched_pkg.sv
// Shared types for the batch sequencer: scheduler FSM states and completion
// status codes reported back to the host.
package sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_REPORT,
        S_GAP
    } sched_state_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_EMPTY   = 2'b01,
        ST_TIMEOUT = 2'b10
    } cmp_status_t;

endpackage

// File: rtl/sched_fifo.sv
// Synchronous job FIFO with full/empty flags; head entry is visible on rdata
// without a read strobe so the scheduler can inspect it before popping.
module sched_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/batch_sequencer.sv
// Job scheduler in front of the word-compaction engine: queues host jobs and
// runs them one at a time. Optional RUN timeout enabled by SCHED_WATCHDOG_EN.
module batch_sequencer
    import sched_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned WDOG_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [ADDR_W-1:0] job_base,
    input  logic [CNT_W-1:0]  job_len,
    input  logic [TAG_W-1:0]  job_tag,
    output logic              eng_start,
    output logic [ADDR_W-1:0] eng_base,
    output logic [CNT_W-1:0]  eng_len,
    input  logic              eng_done,
    output logic              eng_kill,
    output logic              cmp_valid,
    input  logic              cmp_ready,
    output logic [TAG_W-1:0]  cmp_tag,
    output logic [1:0]        cmp_status,
    output logic              busy,
    output logic [15:0]       jobs_done
);

    localparam int unsigned JOB_W = ADDR_W + CNT_W + TAG_W;

    sched_state_t      state_q;
    sched_state_t      state_d;
    cmp_status_t       status_q;
    cmp_status_t       status_d;
    logic              status_we;
    logic              pop;
    logic              push;
    logic              hs;
    logic              fifo_full;
    logic              fifo_empty;
    logic              wdog_expired;
    logic [JOB_W-1:0]  head;
    logic [ADDR_W-1:0] head_base;
    logic [CNT_W-1:0]  head_len;
    logic [TAG_W-1:0]  head_tag;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  len_q;
    logic [TAG_W-1:0]  tag_q;
    logic [15:0]       done_cnt_q;

    assign push      = job_valid & ~fifo_full;
    assign job_ready = ~fifo_full;
    assign {head_base, head_len, head_tag} = head;

    sched_fifo #(
        .WIDTH (JOB_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({job_base, job_len, job_tag}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef SCHED_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(WDOG_CYCLES);

    logic [WDW-1:0] wdog_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
        end else if (state_q == S_RUN) begin
            wdog_q <= wdog_q + 1'b1;
        end else begin
            wdog_q <= '0;
        end
    end

    assign wdog_expired = (state_q == S_RUN) && (wdog_q == WDW'(WDOG_CYCLES - 1));
`else
    assign wdog_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        status_we = 1'b0;
        status_d  = ST_OK;
        hs        = 1'b0;
        eng_start = 1'b0;
        eng_kill  = 1'b0;
        cmp_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_len != '0) begin
                        state_d = S_LAUNCH;
                    end else begin
                        state_d   = S_REPORT;
                        status_we = 1'b1;
                        status_d  = ST_EMPTY;
                    end
                end
            end
            S_LAUNCH: begin
                eng_start = 1'b1;
                state_d   = S_RUN;
            end
            S_RUN: begin
                // A done pulse wins over a simultaneous timeout.
                if (eng_done) begin
                    state_d   = S_REPORT;
                    status_we = 1'b1;
                    status_d  = ST_OK;
                end else if (wdog_expired) begin
                    state_d   = S_REPORT;
                    status_we = 1'b1;
                    status_d  = ST_TIMEOUT;
                    eng_kill  = 1'b1;
                end
            end
            S_REPORT: begin
                cmp_valid = 1'b1;
                if (cmp_ready) begin
                    hs      = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            tag_q      <= '0;
            status_q   <= ST_OK;
            done_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                base_q <= head_base;
                len_q  <= head_len;
                tag_q  <= head_tag;
            end
            if (status_we) status_q <= status_d;
            if (hs) done_cnt_q <= done_cnt_q + 16'd1;
        end
    end

    assign eng_base   = base_q;
    assign eng_len    = len_q;
    assign cmp_tag    = tag_q;
    assign cmp_status = status_q;
    assign jobs_done  = done_cnt_q;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_batch_sequencer.sv
// Directed bench for batch_sequencer with a transaction-level scoreboard that
// checks engine launches, completions, flow control and busy every cycle.
module tb_batch_sequencer;

    localparam int DEPTH   = 4;
    localparam int WDOG_TB = 16;

    typedef struct {
        logic [7:0] base;
        logic [7:0] len;
        logic [3:0] tag;
        int         delay;
    } job_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       job_valid;
    logic       job_ready;
    logic [7:0] job_base;
    logic [7:0] job_len;
    logic [3:0] job_tag;
    logic       eng_start;
    logic [7:0] eng_base;
    logic [7:0] eng_len;
    logic       eng_done;
    logic       eng_kill;
    logic       cmp_valid;
    logic       cmp_ready;
    logic [3:0] cmp_tag;
    logic [1:0] cmp_status;
    logic       busy;
    logic [15:0] jobs_done;

    int checks = 0;
    int errors = 0;

    int   delay_of_tag [16];
    logic stray_done;
    int   n_starts = 0;

    job_t acc_q[$];
    job_t start_q[$];
    job_t act;
    bit   act_v;
    int   accepted, popped, hs_cnt, since_hs, timer, kill_seen;
    bit   prev_start, prev_cv;
    logic [3:0] prev_tag;
    logic [1:0] prev_st;

    always #5 clk = ~clk;

    batch_sequencer #(
        .ADDR_W      (8),
        .CNT_W       (8),
        .TAG_W       (4),
        .FIFO_DEPTH  (DEPTH),
        .WDOG_CYCLES (WDOG_TB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_base   (job_base),
        .job_len    (job_len),
        .job_tag    (job_tag),
        .eng_start  (eng_start),
        .eng_base   (eng_base),
        .eng_len    (eng_len),
        .eng_done   (eng_done),
        .eng_kill   (eng_kill),
        .cmp_valid  (cmp_valid),
        .cmp_ready  (cmp_ready),
        .cmp_tag    (cmp_tag),
        .cmp_status (cmp_status),
        .busy       (busy),
        .jobs_done  (jobs_done)
    );

    task automatic chk(input string name, input longint act_v_, input longint exp_v);
        checks++;
        if (act_v_ != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act_v_, exp_v, $time);
        end
    endtask

    // Completion status implied by the job and how the bench engine answers it.
    function automatic logic [1:0] exp_status(input job_t j);
        if (j.len == 8'd0) return 2'b01;
`ifdef SCHED_WATCHDOG_EN
        if (j.delay == 0 || j.delay > WDOG_TB) return 2'b10;
`endif
        return 2'b00;
    endfunction

    // Scoreboard and engine responder: sampled just after each falling edge.
    initial begin : compare
        eng_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                eng_done = 1'b0;
                acc_q.delete();
                start_q.delete();
                act_v = 0; accepted = 0; popped = 0; hs_cnt = 0;
                since_hs = 1000; timer = 0; kill_seen = 0;
                prev_start = 0; prev_cv = 0; prev_tag = '0; prev_st = '0;
            end else begin
                eng_done = stray_done;
                if (timer > 0) begin
                    timer--;
                    if (timer == 0) eng_done = 1'b1;
                end
                #1;
                if (since_hs < 1000) since_hs++;
                chk("jobs_done", jobs_done, hs_cnt & 16'hFFFF);
                chk("busy", busy, ((accepted - hs_cnt) > 0 || since_hs == 1) ? 1 : 0);
`ifndef SCHED_WATCHDOG_EN
                chk("eng_kill_off", eng_kill, 0);
`endif
                if (eng_start) begin
                    n_starts++;
                    chk("start_one_cycle", prev_start, 0);
                    if (start_q.size() == 0 || acc_q.size() == 0) begin
                        chk("start_unexpected", 1, 0);
                    end else begin
                        act = start_q.pop_front();
                        act_v = 1; kill_seen = 0; timer = act.delay;
                        popped++;
                        chk("start_in_order", acc_q[0].tag, act.tag);
                        if (hs_cnt > 0) chk("start_spacing", (since_hs >= 2) ? 1 : 0, 1);
                    end
                end
                if (act_v) begin
                    chk("eng_base", eng_base, act.base);
                    chk("eng_len", eng_len, act.len);
                end
                if (eng_kill) begin
                    if (!act_v) chk("kill_spurious", 1, 0);
                    kill_seen++;
                end
                if (cmp_valid) begin
                    if (acc_q.size() == 0) begin
                        chk("cmp_spurious", 1, 0);
                    end else begin
                        if (!prev_cv && acc_q[0].len == 8'd0) popped++;
                        if (prev_cv) begin
                            chk("cmp_tag_stable", cmp_tag, prev_tag);
                            chk("cmp_status_stable", cmp_status, prev_st);
                        end
                        if (cmp_ready) begin
                            chk("cmp_tag", cmp_tag, acc_q[0].tag);
                            chk("cmp_status", cmp_status, exp_status(acc_q[0]));
                            if (acc_q[0].len != 8'd0) begin
                                chk("kill_count", kill_seen, (exp_status(acc_q[0]) == 2'b10) ? 1 : 0);
                                act_v = 0;
                            end
                            void'(acc_q.pop_front());
                            hs_cnt++;
                            since_hs = 0;
                        end
                    end
                end
                chk("job_ready", job_ready, ((accepted - popped) < DEPTH) ? 1 : 0);
                if (job_valid && job_ready) begin
                    job_t j;
                    j.base = job_base; j.len = job_len; j.tag = job_tag;
                    j.delay = delay_of_tag[job_tag];
                    acc_q.push_back(j);
                    if (job_len != 8'd0) start_q.push_back(j);
                    accepted++;
                end
                prev_start = eng_start;
                prev_cv    = cmp_valid && !cmp_ready;
                prev_tag   = cmp_tag;
                prev_st    = cmp_status;
            end
        end
    end

    // Called and returns just after a rising edge.
    task automatic push_job(input logic [7:0] b, input logic [7:0] l, input logic [3:0] t, input int d);
        int n = 0;
        delay_of_tag[t] = d;
        job_valid = 1'b1; job_base = b; job_len = l; job_tag = t;
        do begin @(negedge clk); n++; end while (!job_ready && n < 1000);
        chk("push_accept", job_ready, 1);
        @(posedge clk); #1;
        job_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        do begin @(negedge clk); n++; end while (busy && n < max);
        chk("idle_reached", busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_cmp(input int max);
        int n = 0;
        while (!cmp_valid && n < max) begin @(negedge clk); n++; end
        chk("cmp_valid_reached", cmp_valid, 1);
    endtask

    initial begin : watchdog_guard
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int s0;
        rst = 1'b0; job_valid = 1'b0; job_base = '0; job_len = '0; job_tag = '0;
        cmp_ready = 1'b1; stray_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_job_ready", job_ready, 1);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_cmp_valid", cmp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_jobs_done", jobs_done, 0);
        chk("rst_eng_kill", eng_kill, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // Single job; launch one cycle after acceptance.
        push_job(8'h10, 8'd4, 4'd3, 20);
        @(negedge clk); chk("t1_no_start_yet", eng_start, 0);
        @(negedge clk); chk("t1_start", eng_start, 1);
        chk("t1_base", eng_base, 8'h10);
        chk("t1_len", eng_len, 4);
        wait_cmp(100);
        chk("t1_tag", cmp_tag, 3);
`ifdef SCHED_WATCHDOG_EN
        chk("t1_status", cmp_status, 2);
`else
        chk("t1_status", cmp_status, 0);
`endif
        wait_idle(100);
        chk("t1_jobs_done", jobs_done, 1);

        // Five back-to-back jobs fill the queue while the first one runs.
        for (int i = 0; i < 5; i++) push_job(8'h20 + 8'(i), 8'(i + 1), 4'(i), 12);
        @(negedge clk);
        chk("t2_queue_full", job_ready, 0);
        chk("t2_busy", busy, 1);
        wait_idle(1000);
        chk("t2_jobs_done", jobs_done, 6);

        // Zero-length job never touches the engine.
        s0 = n_starts;
        push_job(8'h55, 8'd0, 4'd7, 5);
        @(negedge clk); chk("t3_not_yet", cmp_valid, 0);
        @(negedge clk); chk("t3_cmp_valid", cmp_valid, 1);
        chk("t3_status", cmp_status, 1);
        chk("t3_tag", cmp_tag, 7);
        wait_idle(100);
        chk("t3_no_start", n_starts, s0);
        chk("t3_jobs_done", jobs_done, 7);

        // Host stalls the completion; engine must not restart meanwhile.
        cmp_ready = 1'b0;
        push_job(8'h40, 8'd2, 4'd8, 3);
        push_job(8'h48, 8'd1, 4'd9, 2);
        wait_cmp(100);
        s0 = n_starts;
        repeat (10) begin
            @(negedge clk);
            chk("t4_hold_valid", cmp_valid, 1);
            chk("t4_hold_tag", cmp_tag, 8);
            chk("t4_hold_status", cmp_status, 0);
        end
        chk("t4_no_restart", n_starts, s0);
        @(posedge clk); #1 cmp_ready = 1'b1;
        wait_idle(200);
        chk("t4_jobs_done", jobs_done, 9);

        // Done pulse outside RUN is ignored.
        stray_done = 1'b1;
        @(posedge clk); #1 stray_done = 1'b0;
        repeat (3) begin @(negedge clk); chk("stray_no_cmp", cmp_valid, 0); end
        @(posedge clk); #1;

`ifdef SCHED_WATCHDOG_EN
        // Hung engine times out; done coinciding with expiry counts as ok.
        push_job(8'h60, 8'd3, 4'd10, 0);
        push_job(8'h68, 8'd2, 4'd11, WDOG_TB);
        push_job(8'h70, 8'd1, 4'd12, 5);
        wait_idle(1000);
        chk("t5_jobs_done", jobs_done, 12);
`endif

        // Asynchronous reset mid-RUN with jobs still queued.
        push_job(8'h80, 8'd5, 4'd13, 0);
        push_job(8'h88, 8'd1, 4'd14, 2);
        push_job(8'h90, 8'd1, 4'd15, 2);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_eng_start", eng_start, 0);
        chk("rst_mid_cmp_valid", cmp_valid, 0);
        chk("rst_mid_job_ready", job_ready, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_jobs_done", jobs_done, 0);
        chk("rst_mid_eng_len", eng_len, 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        push_job(8'hA0, 8'd2, 4'd1, 3);
        wait_idle(200);
        chk("post_rst_jobs_done", jobs_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
